ahb_lsu_master: RTL and testbench
=================================

Name: ahb_lsu_master

Overview:
- AHB-Lite single-transfer master between the core load/store unit and the AHB bus. The AHB memory slaves (data RAM) sit downstream of it.
- Accepts one LSU request at a time and drives one NONSEQ address phase, then one data phase.
- Returns read data, aligned and zero-extended, with a one-cycle response pulse.
- Replicates write data across byte lanes, so slaves that take byte/halfword data from HWDATA[7:0]/[15:0] and slaves that take it from the addressed lane both work.

Parameters:
- ALIGN_RDATA, 1: 1 = shift read data right by 8*addr[1:0] and zero-extend to the access size; 0 = return raw HRDATA.

Ports:
- HCLK  in  1  bus clock; all state updates on the rising edge.
- HRESET  in  1  asynchronous, active-high reset.
- req_valid  in  1  LSU request valid.
- req_ready  out  1  high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_size  in  3  000 byte, 001 half, 010 word.
- req_wdata  in  32  store data, LSB-aligned.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  load data, valid with resp_valid.
- resp_err  out  1  bus error or misaligned/unsupported access, valid with resp_valid.
- HADDR  out  32  AHB address.
- HTRANS  out  2  00 IDLE, 10 NONSEQ only.
- HWRITE  out  1  AHB write.
- HSIZE  out  3  AHB size.
- HBURST  out  3  constant 000 (SINGLE).
- HWDATA  out  32  AHB write data.
- HREADY  in  1  bus ready.
- HRDATA  in  32  AHB read data.
- HRESP  in  2  bit0 = ERROR.

Behaviour:
- Reset (async, HRESET=1): state IDLE; HADDR, HTRANS, HWRITE, HSIZE, HWDATA, resp_valid, resp_rdata, resp_err all 0; req_ready=1 once out of reset.
- States: IDLE, ADDR, DATA.
- IDLE:
  - req_ready=1, HTRANS=00.
  - A request is accepted on an edge where req_valid=1.
  - Aligned request: register addr/size/we/wdata onto HADDR/HSIZE/HWRITE and the wdata holding register; next state ADDR.
  - Misaligned request (half with addr[0]=1, word with addr[1:0]!=00) or req_size>010: no bus transfer; next cycle resp_valid=1, resp_err=1, resp_rdata=0; stay IDLE.
- ADDR:
  - HTRANS=10; HADDR/HWRITE/HSIZE stable.
  - Edge with HREADY=1 → DATA. HREADY=0 → hold ADDR with all outputs stable.
- DATA:
  - HTRANS=00. HADDR/HSIZE/HWRITE held (don't-care to slaves).
  - HWDATA driven from the registered wdata for the whole data phase: byte → {4{b[7:0]}}; half → {2{h[15:0]}}; word unchanged.
  - Edge with HREADY=1 → IDLE. On that edge: resp_valid←1; resp_err←HRESP[0]; resp_rdata←processed HRDATA for reads, 0 for writes.
  - ERROR first cycle (HRESP[0]=1, HREADY=0): HTRANS stays 00 and the master waits; the error completes on the HREADY=1 cycle.
- Read data processing, ALIGN_RDATA=1: shifted = HRDATA >> (8*HADDR[1:0]); byte → {24'b0, shifted[7:0]}; half → {16'b0, shifted[15:0]}; word → HRDATA. Sign extension belongs to the core, not this block.
- resp_valid/resp_err are single-cycle pulses, cleared the next edge. resp_rdata holds its value until the next completion.
- Back-to-back: the response cycle is an IDLE cycle, so a new request can be accepted in the same cycle resp_valid=1. Minimum spacing is 3 cycles per transfer: accept at T0, address phase T1, data phase T2, resp_valid T3.
- Reset mid-transfer: immediate return to IDLE with HTRANS=00; no response is generated for the aborted transfer.
- Only one transfer is ever outstanding. No pipelined address phases; no bursts; no locked transfers.

Test Plan:
- Word write, zero wait: req addr=0x100, wdata=0xDEADBEEF, size=010, we=1 → T1 HTRANS=10, HADDR=0x100, HWRITE=1; T2 HWDATA=0xDEADBEEF; T3 resp_valid=1, resp_err=0.
- Byte store/load: store addr=0x103, wdata=0x000000A5, size=000 → HWDATA=0xA5A5A5A5. Load addr=0x103 with HRDATA=0xA5000000 → resp_rdata=0x000000A5. With ALIGN_RDATA=0 → resp_rdata=0xA5000000.
- Wait states: HREADY held low 2 cycles in ADDR and 3 cycles in DATA → HADDR/HTRANS and HWDATA stay stable throughout; resp_valid rises exactly one cycle after the HREADY=1 data edge.
- Misaligned half: addr=0x201, size=001 → HTRANS stays 00 every cycle; next cycle resp_valid=1, resp_err=1; req_ready stays 1.
- Bus error: two-cycle ERROR response (HRESP=01 with HREADY=0, then HRESP=01 with HREADY=1) → HTRANS=00 throughout DATA; resp_err=1 with resp_valid; next request accepted normally.
- Reset in DATA: HRESET pulsed during a load's data phase → HTRANS=00 immediately; no resp_valid; req_ready=1 after release.

Source files
------------

// File: rtl/ahb_lsu_master.sv
// AHB-Lite single-transfer master bridging the core load/store unit onto the bus.
// One request outstanding at a time: accept, NONSEQ address phase, data phase, response pulse.
module ahb_lsu_master #(
  parameter bit ALIGN_RDATA = 1'b1
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_size,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [31:0] HWDATA,
  input  logic        HREADY,
  input  logic [31:0] HRDATA,
  input  logic [1:0]  HRESP
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] wdata_q;
  logic        misaligned;
  logic        unused_hresp;

  assign unused_hresp = HRESP[1];

  // Shift the addressed lane down and zero-extend; sign extension is left to the core.
  function automatic logic [31:0] align_rdata(input logic [31:0] d,
                                              input logic [1:0]  off,
                                              input logic [2:0]  sz);
    logic [31:0] shifted;
    shifted = d >> {off, 3'b000};
    if (!ALIGN_RDATA) return d;
    case (sz)
      3'b000:  return {24'b0, shifted[7:0]};
      3'b001:  return {16'b0, shifted[15:0]};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] replicate_wdata(input logic [31:0] w,
                                                  input logic [2:0]  sz);
    case (sz)
      3'b000:  return {4{w[7:0]}};
      3'b001:  return {2{w[15:0]}};
      default: return w;
    endcase
  endfunction

  always_comb begin
    misaligned = (req_size > 3'b010)
               | ((req_size == 3'b001) & req_addr[0])
               | ((req_size == 3'b010) & (|req_addr[1:0]));
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    HTRANS    = 2'b00;
    HBURST    = 3'b000;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid && !misaligned) state_nxt = S_ADDR;
      end
      S_ADDR: begin
        HTRANS = 2'b10;
        if (HREADY) state_nxt = S_DATA;
      end
      S_DATA: begin
        if (HREADY) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign HWDATA = replicate_wdata(wdata_q, HSIZE);

  // Request capture (IDLE) and response generation (last data-phase edge).
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      HADDR      <= '0;
      HWRITE     <= 1'b0;
      HSIZE      <= '0;
      wdata_q    <= '0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
    end else begin
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            if (misaligned) begin
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else begin
              HADDR   <= req_addr;
              HWRITE  <= req_we;
              HSIZE   <= req_size;
              wdata_q <= req_wdata;
            end
          end
        end
        S_DATA: begin
          if (HREADY) begin
            resp_valid <= 1'b1;
            resp_err   <= HRESP[0];
            resp_rdata <= HWRITE ? 32'h0 : align_rdata(HRDATA, HADDR[1:0], HSIZE);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_lsu_master.sv
// Directed bench for ahb_lsu_master: bus-side checks inline, responses via a scoreboard queue.
// A second instance with raw read data shares all inputs.
module tb_ahb_lsu_master;

  logic        HCLK = 1'b0;
  logic        HRESET = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [2:0]  req_size = '0;
  logic [31:0] req_wdata = '0;
  logic        HREADY = 1'b1;
  logic [31:0] HRDATA = '0;
  logic [1:0]  HRESP = '0;

  logic        req_ready, resp_valid, resp_err, HWRITE;
  logic [31:0] resp_rdata, HADDR, HWDATA;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE, HBURST;

  logic        r_req_ready, r_resp_valid, r_resp_err, r_HWRITE;
  logic [31:0] r_resp_rdata, r_HADDR, r_HWDATA;
  logic [1:0]  r_HTRANS;
  logic [2:0]  r_HSIZE, r_HBURST;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    logic [31:0] raw;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  always #5 HCLK = ~HCLK;

  ahb_lsu_master #(.ALIGN_RDATA(1'b1)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
    .HWDATA(HWDATA), .HREADY(HREADY), .HRDATA(HRDATA), .HRESP(HRESP)
  );

  ahb_lsu_master #(.ALIGN_RDATA(1'b0)) dut_raw (
    .HCLK(HCLK), .HRESET(HRESET), .req_valid(req_valid), .req_ready(r_req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
    .resp_valid(r_resp_valid), .resp_rdata(r_resp_rdata), .resp_err(r_resp_err),
    .HADDR(r_HADDR), .HTRANS(r_HTRANS), .HWRITE(r_HWRITE), .HSIZE(r_HSIZE), .HBURST(r_HBURST),
    .HWDATA(r_HWDATA), .HREADY(HREADY), .HRDATA(HRDATA), .HRESP(HRESP)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Response monitor: every resp_valid pulse must match the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge HCLK);
      if (resp_valid === 1'b1) begin
        check("raw_resp_valid", {31'b0, r_resp_valid}, 32'h1);
        if (exp_q.size() == 0) begin
          check("unexpected_resp", 32'h1, 32'h0);
        end else begin
          e = exp_q.pop_front();
          check("resp_err", {31'b0, resp_err}, {31'b0, e.err});
          check("resp_rdata", resp_rdata, e.rdata);
          check("raw_resp_err", {31'b0, r_resp_err}, {31'b0, e.err});
          check("raw_resp_rdata", r_resp_rdata, e.raw);
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge where resp_valid is expected high.
  task automatic xfer(input logic we, input logic [31:0] addr, input logic [2:0] size,
                      input logic [31:0] wdata, input logic [31:0] hrdata,
                      input int aw, input int dw, input logic err,
                      input logic [31:0] exp_hwdata, input logic [31:0] exp_rdata,
                      input logic [31:0] exp_raw);
    exp_t e;
    e.err = err; e.rdata = exp_rdata; e.raw = exp_raw;
    check("req_ready_idle", {31'b0, req_ready}, 32'h1);
    exp_q.push_back(e);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size; req_wdata = wdata;
    HREADY = 1'b1; HRESP = 2'b00;
    @(negedge HCLK);
    req_valid = 1'b0; req_wdata = 32'h0;
    check("addr_htrans", {30'b0, HTRANS}, 32'h2);
    check("addr_haddr", HADDR, addr);
    check("addr_hwrite", {31'b0, HWRITE}, {31'b0, we});
    check("addr_hsize", {29'b0, HSIZE}, {29'b0, size});
    check("req_ready_busy", {31'b0, req_ready}, 32'h0);
    for (int i = 0; i < aw; i++) begin
      HREADY = 1'b0;
      @(negedge HCLK);
      check("addr_wait_htrans", {30'b0, HTRANS}, 32'h2);
      check("addr_wait_haddr", HADDR, addr);
    end
    HREADY = 1'b1;
    @(negedge HCLK);
    HRDATA = hrdata;
    HRESP = {1'b0, err};
    check("data_htrans", {30'b0, HTRANS}, 32'h0);
    if (we) check("data_hwdata", HWDATA, exp_hwdata);
    for (int i = 0; i < dw; i++) begin
      HREADY = 1'b0;
      @(negedge HCLK);
      check("data_wait_htrans", {30'b0, HTRANS}, 32'h0);
      check("data_wait_resp_valid", {31'b0, resp_valid}, 32'h0);
      if (we) check("data_wait_hwdata", HWDATA, exp_hwdata);
    end
    HREADY = 1'b1;
    @(negedge HCLK);
    HRESP = 2'b00; HRDATA = 32'h0;
    check("resp_valid_timing", {31'b0, resp_valid}, 32'h1);
  endtask

  task automatic bad_req(input logic [31:0] addr, input logic [2:0] size);
    exp_t e;
    e.err = 1'b1; e.rdata = 32'h0; e.raw = 32'h0;
    exp_q.push_back(e);
    req_valid = 1'b1; req_we = 1'b0; req_addr = addr; req_size = size;
    @(negedge HCLK);
    req_valid = 1'b0;
    check("bad_htrans", {30'b0, HTRANS}, 32'h0);
    check("bad_req_ready", {31'b0, req_ready}, 32'h1);
    check("bad_resp_valid", {31'b0, resp_valid}, 32'h1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge HCLK);
    check("rst_haddr", HADDR, 32'h0);
    check("rst_htrans", {30'b0, HTRANS}, 32'h0);
    check("rst_hwrite", {31'b0, HWRITE}, 32'h0);
    check("rst_hsize", {29'b0, HSIZE}, 32'h0);
    check("rst_hwdata", HWDATA, 32'h0);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_resp_err", {31'b0, resp_err}, 32'h0);
    HRESET = 1'b0;
    @(negedge HCLK);
    check("hburst", {29'b0, HBURST}, 32'h0);

    // Transfers chain back-to-back: each starts on the previous response cycle.
    xfer(1'b1, 32'h100, 3'b010, 32'hDEADBEEF, 32'h0, 0, 0, 1'b0, 32'hDEADBEEF, 32'h0, 32'h0);
    xfer(1'b1, 32'h103, 3'b000, 32'h000000A5, 32'h0, 0, 0, 1'b0, 32'hA5A5A5A5, 32'h0, 32'h0);
    xfer(1'b0, 32'h103, 3'b000, 32'h0, 32'hA5000000, 0, 0, 1'b0, 32'h0, 32'h000000A5, 32'hA5000000);
    xfer(1'b0, 32'h102, 3'b001, 32'h0, 32'h1234ABCD, 2, 3, 1'b0, 32'h0, 32'h00001234, 32'h1234ABCD);
    xfer(1'b1, 32'h202, 3'b001, 32'hFFFF5A3C, 32'h0, 2, 3, 1'b0, 32'h5A3C5A3C, 32'h0, 32'h0);
    xfer(1'b0, 32'h300, 3'b010, 32'h0, 32'hCAFEF00D, 0, 1, 1'b0, 32'h0, 32'hCAFEF00D, 32'hCAFEF00D);
    xfer(1'b0, 32'h101, 3'b000, 32'h0, 32'h11223344, 1, 0, 1'b0, 32'h0, 32'h00000033, 32'h11223344);

    bad_req(32'h201, 3'b001);
    bad_req(32'h102, 3'b010);
    bad_req(32'h000, 3'b011);
    @(negedge HCLK);
    check("after_bad_resp_valid", {31'b0, resp_valid}, 32'h0);
    check("after_bad_htrans", {30'b0, HTRANS}, 32'h0);

    // Two-cycle ERROR response, then a normal request.
    xfer(1'b0, 32'h400, 3'b010, 32'h0, 32'h0, 0, 1, 1'b1, 32'h0, 32'h0, 32'h0);
    xfer(1'b1, 32'h404, 3'b010, 32'h01020304, 32'h0, 0, 0, 1'b0, 32'h01020304, 32'h0, 32'h0);

    // Reset during a load's data phase: abort, no response.
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h508; req_size = 3'b010;
    @(negedge HCLK);
    req_valid = 1'b0;
    @(negedge HCLK);
    HREADY = 1'b0;
    check("rst_mid_data_htrans", {30'b0, HTRANS}, 32'h0);
    #2 HRESET = 1'b1;
    #1 check("rst_mid_htrans", {30'b0, HTRANS}, 32'h0);
    check("rst_mid_haddr", HADDR, 32'h0);
    @(negedge HCLK);
    HRESET = 1'b0; HREADY = 1'b1;
    @(negedge HCLK);
    check("post_rst_req_ready", {31'b0, req_ready}, 32'h1);
    check("post_rst_resp_valid", {31'b0, resp_valid}, 32'h0);
    check("post_rst_htrans", {30'b0, HTRANS}, 32'h0);
    @(negedge HCLK);
    check("post_rst_resp_valid2", {31'b0, resp_valid}, 32'h0);

    xfer(1'b0, 32'h600, 3'b001, 32'h0, 32'h0000BEEF, 0, 0, 1'b0, 32'h0, 32'h0000BEEF, 32'h0000BEEF);
    repeat (3) @(negedge HCLK);
    check("scoreboard_drained", exp_q.size(), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
